// File: rtl/piso_pkg.sv
// Shared constants for the parallel-in serial-out shift register.
// Bit order is selected at build time with PISO_LSB_FIRST_EN (undefined = MSB first).
package piso_pkg;

    localparam int WIDTH_DEF = 4;

    // Counter width able to hold the values 0..w
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/piso_shift_reg_if.sv
// Parallel source / serial sink signal bundle for piso_shift_reg.
// master: the parallel data source; slave: the shift register itself.
interface piso_shift_reg_if
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             load;
    logic [WIDTH-1:0] din;
    logic             q;
    logic             busy;

    modport master (output load, output din, input q, input busy);
    modport slave  (input load, input din, output q, output busy);

endinterface

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter tracking how many frame bits remain on q.
// Reloads to WIDTH on load, otherwise counts down and sticks at zero.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart the frame on load, else decrement saturating at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: captures din on load and emits it
// one bit per clock on q while busy is high.
// PISO_LSB_FIRST_EN defined: din[0] goes out first; undefined: din[WIDTH-1] first.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    piso_shift_reg_if.slave        bus
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next shift register value: capture a new word or shift toward the output end
    always_comb begin
        shreg_d = shreg_q;
        if (bus.load) begin
            shreg_d = bus.din;
        end else begin
`ifdef PISO_LSB_FIRST_EN
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
        end
    end

    // Shift register storage, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // The serial output is the head bit taken straight from the register
`ifdef PISO_LSB_FIRST_EN
    assign bus.q = shreg_q[0];
`else
    assign bus.q = shreg_q[WIDTH-1];
`endif

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (bus.load),
        .busy (bus.busy)
    );

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: directed stimulus pushes the expected
// {q, busy} for each clock into a scoreboard, a monitor pops and compares.
module tb_piso_shift_reg;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [1:0] exp_queue[$];
    string      name_queue[$];

    piso_shift_reg_if #(.WIDTH(4)) bus ();

    piso_shift_reg #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected serial sequences, first output bit in the MSB position
`ifdef PISO_LSB_FIRST_EN
    localparam logic [4:0] T2_Q = 5'b01010;
    localparam logic [5:0] T3_Q = 6'b101100;
    localparam logic [6:0] T4_Q = 7'b0111100;
`else
    localparam logic [4:0] T2_Q = 5'b10100;
    localparam logic [5:0] T3_Q = 6'b110100;
    localparam logic [6:0] T4_Q = 7'b1001110;
`endif

    // Compare the live outputs against the required values
    task automatic checkOutput(input string nm, input logic exp_q, input logic exp_busy);
        checks++;
        if (bus.q !== exp_q || bus.busy !== exp_busy) begin
            errors++;
            $display("[TB] FAIL %s: got q=%b busy=%b, required q=%b busy=%b",
                     nm, bus.q, bus.busy, exp_q, exp_busy);
        end
    endtask

    // Drive one clock of stimulus and queue the outputs expected after that edge
    task automatic applyStimulus(input logic ld, input logic [3:0] d,
                                 input logic exp_q, input logic exp_busy, input string nm);
        @(negedge clk);
        bus.load = ld;
        bus.din  = d;
        exp_queue.push_back({exp_q, exp_busy});
        name_queue.push_back(nm);
    endtask

    // Monitor: after every rising edge, check the oldest pending expectation
    always @(posedge clk) begin
        logic [1:0] e;
        string      nm;
        #1;
        if (exp_queue.size() > 0) begin
            e  = exp_queue.pop_front();
            nm = name_queue.pop_front();
            checkOutput(nm, e[1], e[0]);
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        bus.load = 1'b0;
        bus.din  = 4'b0000;

        // Reset held, then released
        #8;
        checkOutput("reset_hold", 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, "after_reset_idle");

        // Frame 1010 followed by four shifts
        applyStimulus(1'b1, 4'b1010, T2_Q[4], 1'b1, "t2_load");
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b0, 4'b0000, T2_Q[i], (i != 0), $sformatf("t2_shift%0d", 4 - i));
        end

        // Frame 1101 followed by five shifts
        applyStimulus(1'b1, 4'b1101, T3_Q[5], 1'b1, "t3_load");
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1'b0, 4'b0000, T3_Q[i], (i > 1), $sformatf("t3_shift%0d", 5 - i));
        end

        // Reload in the middle of a frame discards the remaining old bits
        applyStimulus(1'b1, 4'b1010, T4_Q[6], 1'b1, "t4_load_a");
        applyStimulus(1'b0, 4'b0000, T4_Q[5], 1'b1, "t4_shift_a");
        applyStimulus(1'b1, 4'b0111, T4_Q[4], 1'b1, "t4_load_b");
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b0, 4'b0000, T4_Q[i], (i != 0), $sformatf("t4_shift_b%0d", 4 - i));
        end

        // Continuous load keeps q on the head bit; din ignored once load drops
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1, "cont_load1");
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1, "cont_load2");
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1, "cont_load3");
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1, "din_ignored");

        // Frame 1111, one shift, then asynchronous reset mid-cycle
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, "t5_load");
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, "t5_shift");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t5_async_reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, "t5_after_release");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_queue.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_queue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0",
                     exp_queue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
